uart_ctrl: RTL and testbench
============================

// Module: uart_ctrl
// PURPOSE
//  Self-contained UART transceiver with internal loopback: 8N1 transmitter plus oversampling receiver.
//  The transmitter's serial output feeds the receiver directly; there is no external RX pin.
//  Used as a link-level check block: a byte written on the TX side reappears on the RX side.
// PARAMETERS
//  CLOCK_RATE     25000000  system clock frequency in Hz
//  BAUD_RATE      9600      serial bit rate in baud
//  RX_OVERSAMPLE  16        receiver sample ticks per bit (even, >=8)
// PORTS
//  clk         in   1  single system clock; all logic on rising edge
//  reset_n     in   1  one clock; reset is synchronous and active-high
//  i_Tx_Byte   in   8  byte to transmit; sampled in the cycle i_Tx_Ready is accepted
//  i_Tx_Ready  in   1  transmit request; accepted only when TX is idle
//  o_Rx_Done   out  1  one-cycle pulse: o_Rx_Byte holds a new valid byte
//  o_Rx_Byte   out  8  last received byte; holds until next good frame
//  o_Tx_Data   out  1  serial TX line; idle high; also drives internal RX input
// BEHAVIOUR
//  - Reset (reset_n=1 at clk edge): o_Tx_Data=1, o_Rx_Done=0, o_Rx_Byte=8'h00, both FSMs IDLE,
//    all counters 0. Reset mid-frame aborts both frames immediately; no o_Rx_Done is produced.
//  - TX_DIV = CLOCK_RATE/BAUD_RATE (truncating; 2604 at defaults).
//    RX_DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE) (truncating; 162 at defaults).
//  - TX FSM IDLE->START->DATA->STOP->IDLE; each state lasts exactly TX_DIV clocks per bit.
//    IDLE: line 1. If i_Tx_Ready=1, latch i_Tx_Byte and go to START on the next edge.
//    START: line 0. DATA: 8 bits, LSB first. STOP: line 1, one bit.
//    i_Tx_Ready while not IDLE is ignored (no queue). Held high in IDLE, it starts back-to-back frames.
//  - RX input: internal line = o_Tx_Data, passed through a 2-flop synchronizer (reset value 1).
//    Sample-tick counter restarts at start detection; one tick every RX_DIV clocks.
//  - RX FSM IDLE->START->DATA->STOP->IDLE.
//    IDLE: synced line 0 -> START, clear tick count.
//    START: after RX_OVERSAMPLE/2 ticks, line still 0 -> DATA; else glitch -> IDLE.
//    DATA: sample every RX_OVERSAMPLE ticks (mid-bit), shift in LSB first, 8 samples.
//    STOP: sample mid-bit. If 1, wait the remaining RX_OVERSAMPLE/2 ticks (end of stop bit),
//    then load o_Rx_Byte and pulse o_Rx_Done for exactly 1 clock. If 0 (framing error),
//    return to IDLE without a pulse and leave o_Rx_Byte unchanged.
//  - o_Rx_Done and the o_Rx_Byte update happen in the same clock edge.
//  - Latency: o_Rx_Done occurs within about 10*TX_DIV + 4 clocks of request acceptance.
//    Any residual TX stop-bit time after o_Rx_Done is < RX_OVERSAMPLE*10*(TX_DIV mod ...) drift,
//    i.e. <150 clocks at defaults. A new request accepted 250+ clocks after o_Rx_Done is never dropped.
//  - RX bit-time rounding error must stay < 1/2 bit over 10 bits; check at elaboration, error if violated.
// STRUCTURE
//  - Package uart_pkg: TX/RX state encodings (IDLE, START, DATA, STOP),
//    divisor functions tx_div() and rx_div(), DATA_BITS=8 constant.
//  - One sub-module, uart_rx (synchronizer + RX FSM + tick generator).
//    The TX FSM and loopback wiring live in uart_ctrl.
// TESTING
//  - Reset, then pulse i_Tx_Ready 1 clk with 8'h55 -> line 0,1,0,1,0,1,0,1,0,1,
//    each 2604 clk; o_Rx_Byte=8'h55; o_Rx_Done high exactly 1 clk.
//  - Send 55,AA,0F,F0,33,CC,99,66, each 250 clk after the prior o_Rx_Done -> all 8 received in order, none dropped.
//  - Pulse i_Tx_Ready with 8'hA5 mid-frame of 8'h3C -> only 3C received; A5 never appears.
//  - Assert reset_n for 1 clk at mid-data of 8'hF0 -> o_Tx_Data=1 next clk; no o_Rx_Done; o_Rx_Byte=00.
//  - Hold i_Tx_Ready=1 with 8'h81 for 3 frames -> three o_Rx_Done pulses, each 8'h81, spaced 26040 clk.
//  - After reset, idle 1000 clk -> o_Tx_Data=1 and o_Rx_Done=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the loopback UART: state encodings, divisor helpers, frame width.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Clocks per transmitted bit (truncating).
    function automatic int tx_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

    // Clocks per receiver sample tick (truncating).
    function automatic int rx_div(input int clock_rate, input int baud_rate, input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    // Receiver bit time must stay within half a bit of the transmitter over a
    // 10-bit frame, and the oversample factor must be even and at least 8.
    function automatic bit rx_timing_ok(input int clock_rate, input int baud_rate, input int oversample);
        int tx;
        int rx;
        int err;
        tx  = tx_div(clock_rate, baud_rate);
        rx  = rx_div(clock_rate, baud_rate, oversample);
        err = tx - rx * oversample;
        if (err < 0) begin
            err = -err;
        end
        return (rx >= 1) && (oversample >= 8) && ((oversample % 2) == 0) && ((20 * err) < tx);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver: 2-flop synchronizer, restartable tick divider, framing FSM.
// Latency: o_rx_done rises half a stop bit after the stop-bit mid-sample (~10 bit times from start edge).
// Backpressure: none; o_rx_done is a single-cycle pulse and o_rx_byte holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 9600,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx_line,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_rx_byte
);

    localparam int RX_DIV = rx_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
    localparam int DIV_W  = cnt_width(RX_DIV);
    localparam int TICK_W = cnt_width(RX_OVERSAMPLE + RX_OVERSAMPLE / 2);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(RX_DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST     = TICK_W'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST     = TICK_W'(RX_OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_END_LAST = TICK_W'(RX_OVERSAMPLE + RX_OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 done_q, done_d;

    logic line;
    logic tick;

    assign line      = sync_q[1];
    assign tick      = (div_q == DIV_LAST);
    assign o_rx_done = done_q;
    assign o_rx_byte = byte_q;

    // Next-state logic: synchronizer shift, tick divider and framing FSM.
    always_comb begin
        sync_d     = {sync_q[0], i_rx_line};
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        done_d     = 1'b0;

        case (state_q)
            RX_IDLE: begin
                // Falling edge: realign the tick phase to the start edge.
                if (!line) begin
                    state_d    = RX_START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        if (!line) begin
                            state_d = RX_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {line, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                // Mid-bit check first; a good stop bit is then ridden out to its end
                // so the next start edge cannot be mistaken for stop-bit time.
                if (tick) begin
                    if ((tick_cnt_q == FULL_LAST) && !line) begin
                        state_d    = RX_IDLE;
                        tick_cnt_d = '0;
                    end else if (tick_cnt_q == STOP_END_LAST) begin
                        state_d    = RX_IDLE;
                        tick_cnt_d = '0;
                        byte_d     = shift_q;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state registers; synchronizer resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= RX_IDLE;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Loopback UART: 8N1 transmitter whose line feeds the oversampling receiver directly.
// Latency: o_Rx_Done within ~10*TX_DIV+4 clocks of the accepting edge of i_Tx_Ready.
// Backpressure: i_Tx_Ready is accepted only when the transmitter is free; requests while busy are dropped.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 9600,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,     // active-high synchronous reset despite the name
    input  logic [7:0] i_Tx_Byte,
    input  logic       i_Tx_Ready,
    output logic       o_Rx_Done,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Tx_Data
);

    localparam int TX_DIV = tx_div(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W  = cnt_width(TX_DIV);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    if (!rx_timing_ok(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE)) begin : g_bad_rx_timing
        $error("uart_ctrl: receiver timing unusable (oversample odd/<8, zero tick divisor, or >=1/2 bit drift per frame)");
    end

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;

    logic bit_end;

    assign bit_end   = (tx_cnt_q == TX_LAST);
    assign o_Tx_Data = tx_line_q;

    // Transmit FSM: line level is registered alongside the state so each bit lasts exactly TX_DIV clocks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;

        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (i_Tx_Ready) begin
                    tx_state_d = TX_START;
                    tx_shift_d = i_Tx_Byte;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                // The final stop-bit clock doubles as the idle acceptance slot, so a
                // held request yields frames spaced exactly 10 bit times apart.
                if (bit_end) begin
                    tx_cnt_d = '0;
                    if (i_Tx_Ready) begin
                        tx_state_d = TX_START;
                        tx_shift_d = i_Tx_Byte;
                        tx_line_d  = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_line_d  = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    uart_rx #(
        .CLOCK_RATE    (CLOCK_RATE),
        .BAUD_RATE     (BAUD_RATE),
        .RX_OVERSAMPLE (RX_OVERSAMPLE)
    ) u_rx (
        .clk       (clk),
        .rst       (reset_n),
        .i_rx_line (tx_line_q),
        .o_rx_done (o_Rx_Done),
        .o_rx_byte (o_Rx_Byte)
    );

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed plus randomized bench for the loopback UART, scaled to a 50-clock bit time.
// Latency: n/a (bench).
// Backpressure: the reference model drops requests made while a frame is still on the wire.
`timescale 1ns/1ps
module tb_uart_ctrl;

    localparam int CLOCK_RATE = 5_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int OS         = 16;
    localparam int TX_DIV     = CLOCK_RATE / BAUD_RATE;   // 50 clocks per bit
    localparam int FRAME      = 10 * TX_DIV;              // start + 8 data + stop

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] i_Tx_Byte;
    logic       i_Tx_Ready;
    logic       o_Rx_Done;
    logic [7:0] o_Rx_Byte;
    logic       o_Tx_Data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       prev_done = 1'b0;

    uart_ctrl #(
        .CLOCK_RATE    (CLOCK_RATE),
        .BAUD_RATE     (BAUD_RATE),
        .RX_OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_Tx_Byte  (i_Tx_Byte),
        .i_Tx_Ready (i_Tx_Ready),
        .o_Rx_Done  (o_Rx_Done),
        .o_Rx_Byte  (o_Rx_Byte),
        .o_Tx_Data  (o_Tx_Data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Receive monitor: log every done pulse and insist it never lasts two cycles.
    always @(negedge clk) begin
        if (o_Rx_Done === 1'b1) begin
            check("rx_done_single_cycle", 32'(prev_done), 32'd0);
            rx_q.push_back(o_Rx_Byte);
            rx_t.push_back(cyc);
        end
        prev_done = o_Rx_Done;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-clock request; acc returns the edge number at which it was presented.
    task automatic pulse(input logic [7:0] b, output int acc);
        i_Tx_Byte  = b;
        i_Tx_Ready = 1'b1;
        step(1);
        acc        = cyc;
        i_Tx_Ready = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < limit) begin
            step(1);
            k++;
        end
        check(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    // Expected line level for bit slot k of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        int         acc;
        int         acc2;
        int         base;
        int         bad;
        int         gap;
        int         busy_until;
        logic [7:0] b;
        logic [7:0] seq [8];
        logic [7:0] exp_q[$];

        seq = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h99, 8'h66};

        // Reset state
        reset_n    = 1'b1;
        i_Tx_Ready = 1'b0;
        i_Tx_Byte  = 8'h00;
        step(3);
        check("reset_tx_line", 32'(o_Tx_Data), 32'd1);
        check("reset_rx_done", 32'(o_Rx_Done), 32'd0);
        check("reset_rx_byte", 32'(o_Rx_Byte), 32'h00);
        reset_n = 1'b0;

        // Idle for 1000 clocks: line stays high, nothing received
        bad = 0;
        repeat (1000) begin
            step(1);
            if (o_Tx_Data !== 1'b1 || o_Rx_Done !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_no_rx", 32'(rx_q.size()), 32'd0);

        // Single 0x55 frame: check both edges of every bit slot
        pulse(8'h55, acc);
        for (int off = 0; off < FRAME; off++) begin
            if ((off % TX_DIV) == 0 || (off % TX_DIV) == TX_DIV - 1)
                check("tx_wave_55", 32'(o_Tx_Data), 32'(frame_bit(8'h55, off / TX_DIV)));
            step(1);
        end
        wait_rx(1, 100, "rx55_arrived");
        check("rx55_byte", 32'(rx_q[0]), 32'h55);
        check("rx55_latency", 32'((rx_t[0] - acc) <= FRAME + 4), 32'd1);
        check("rx55_byte_holds", 32'(o_Rx_Byte), 32'h55);

        // Eight bytes, each sent shortly after the previous done pulse
        base = rx_q.size();
        for (int i = 0; i < 8; i++) begin
            pulse(seq[i], acc);
            wait_rx(base + i + 1, FRAME + 50, "seq_arrived");
            check("seq_latency", 32'((rx_t[rx_t.size()-1] - acc) <= FRAME + 4), 32'd1);
            step(20 + $urandom_range(0, 40));
        end
        check("seq_count", 32'(rx_q.size()), 32'(base + 8));
        for (int i = 0; i < 8; i++) check("seq_byte", 32'(rx_q[base+i]), 32'(seq[i]));

        // Request mid-frame is ignored
        base = rx_q.size();
        pulse(8'h3C, acc);
        step(200);
        pulse(8'hA5, acc2);
        wait_rx(base + 1, FRAME, "mid_arrived");
        step(FRAME + 100);
        check("mid_count", 32'(rx_q.size()), 32'(base + 1));
        check("mid_byte", 32'(rx_q[base]), 32'h3C);
        check("mid_line_idle", 32'(o_Tx_Data), 32'd1);

        // One-clock reset in the middle of the data bits of 0xF0
        base = rx_q.size();
        pulse(8'hF0, acc);
        step(125);
        check("pre_rst_line_low", 32'(o_Tx_Data), 32'd0);
        reset_n = 1'b1;
        step(1);
        check("rst_tx_line", 32'(o_Tx_Data), 32'd1);
        check("rst_rx_done", 32'(o_Rx_Done), 32'd0);
        check("rst_rx_byte", 32'(o_Rx_Byte), 32'h00);
        reset_n = 1'b0;
        step(FRAME + 100);
        check("rst_no_rx", 32'(rx_q.size()), 32'(base));
        check("rst_byte_zero", 32'(o_Rx_Byte), 32'h00);

        // Held request: three back-to-back frames of 0x81
        base       = rx_q.size();
        i_Tx_Byte  = 8'h81;
        i_Tx_Ready = 1'b1;
        step(1);
        acc = cyc;
        step(2 * FRAME + 200);
        i_Tx_Ready = 1'b0;
        step(FRAME + 200);
        check("hold_count", 32'(rx_q.size()), 32'(base + 3));
        for (int i = 0; i < 3; i++) check("hold_byte", 32'(rx_q[base+i]), 32'h81);
        check("hold_latency", 32'((rx_t[base] - acc) <= FRAME + 4), 32'd1);
        check("hold_spacing_1", 32'(rx_t[base+1] - rx_t[base]), 32'(FRAME));
        check("hold_spacing_2", 32'(rx_t[base+2] - rx_t[base+1]), 32'(FRAME));

        // Random bytes at random times; model drops requests made while a frame is in flight
        base       = rx_q.size();
        busy_until = 0;
        for (int i = 0; i < 16; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(30, 700);
            step(gap);
            i_Tx_Byte  = b;
            i_Tx_Ready = 1'b1;
            step(1);
            i_Tx_Ready = 1'b0;
            if (cyc >= busy_until) begin
                exp_q.push_back(b);
                busy_until = cyc + FRAME;
            end
        end
        step(FRAME + 100);
        check("rand_count", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check("rand_byte", 32'(rx_q[base+i]), 32'(exp_q[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
